// File: rtl/ctrl_pkg.sv
// Shared controller package: loader state encoding, checksum width and
// default geometry of the weight/input loader instances.
package ctrl_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_FETCH = 2'd1,
        LDR_DRAIN = 2'd2,
        LDR_DONE  = 2'd3
    } ldr_state_e;

    localparam int CHK_W       = 16;
    localparam int LDR_DATA_W  = 8;
    localparam int LDR_ADDR_W  = 10;

    // Weight and input images each live in their own source memory.
    localparam int W_DEPTH     = 784;
    localparam int W_BASE_ADDR = 0;
    localparam int I_DEPTH     = 784;
    localparam int I_BASE_ADDR = 0;

endpackage

// File: rtl/mem_loader_chk.sv
// 16-bit modulo accumulator of loaded words; clear has priority over enable.
module mem_loader_chk
    import ctrl_pkg::*;
#(
    parameter int DATA_W = LDR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [CHK_W-1:0]  sum
);

    logic [CHK_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr)
            sum_d = '0;
        else if (en)
            sum_d = sum_q + CHK_W'(din);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sum_q <= '0;
        else      sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Streams DEPTH words from a sync-read memory into a buffer on a level start
// handshake. Optional checksum port under MEM_LOADER_CHECKSUM_EN.
module mem_loader
    import ctrl_pkg::*;
#(
    parameter int DATA_W    = LDR_DATA_W,
    parameter int ADDR_W    = LDR_ADDR_W,
    parameter int DEPTH     = 784,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              finish,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    output logic [CHK_W-1:0]  checksum
`endif
);

    // One extra count bit keeps the terminal compare exact at DEPTH=2^ADDR_W.
    localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              finish_q, finish_d;

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        finish_d   = finish_q;
        // Write side trails the read side by the memory's one-cycle latency.
        wr_en_d    = mem_en_q;
        wr_addr_d  = rd_cnt_q[ADDR_W-1:0];
        case (state_q)
            LDR_IDLE: begin
                if (start) begin
                    state_d    = LDR_FETCH;
                    rd_cnt_d   = '0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = BASE;
                end
            end
            LDR_FETCH: begin
                if (rd_cnt_q == LAST) begin
                    state_d  = LDR_DRAIN;
                    mem_en_d = 1'b0;
                end else begin
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                    mem_addr_d = BASE + rd_cnt_d[ADDR_W-1:0];
                end
            end
            LDR_DRAIN: begin
                state_d  = LDR_DONE;
                finish_d = 1'b1;
            end
            LDR_DONE: begin
                // A new load only starts from IDLE, never straight from DONE.
                if (!start) begin
                    state_d  = LDR_IDLE;
                    finish_d = 1'b0;
                end
            end
            default: begin
                state_d  = LDR_IDLE;
                mem_en_d = 1'b0;
                finish_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LDR_IDLE;
            rd_cnt_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= BASE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            finish_q   <= finish_d;
        end
    end

    assign finish   = finish_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = mem_rdata;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic chk_clr;
    assign chk_clr = (state_q == LDR_IDLE) && start;

    mem_loader_chk #(.DATA_W(DATA_W)) u_chk (
        .clk (clk),
        .rst (rst),
        .clr (chk_clr),
        .en  (wr_en_q),
        .din (mem_rdata),
        .sum (checksum)
    );
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: basic load, handshake, early drop, async
// reset, back-to-back loads and a full-address-space boundary instance.
module tb_mem_loader;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: ADDR_W=10, DEPTH=4, BASE_ADDR=8
    logic       start_a = 1'b0;
    logic       finish_a, mem_en_a, wr_en_a;
    logic [9:0] mem_addr_a, wr_addr_a;
    logic [7:0] rdata_a, wr_data_a;
    logic [7:0] mem_a [0:1023];
    int         wcnt_a = 0;

    // Instance B: ADDR_W=2, DEPTH=4, BASE_ADDR=0
    logic       start_b = 1'b0;
    logic       finish_b, mem_en_b, wr_en_b;
    logic [1:0] mem_addr_b, wr_addr_b;
    logic [7:0] rdata_b, wr_data_b;
    logic [7:0] mem_b [0:3];
    int         wcnt_b = 0;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [15:0] checksum_a, checksum_b;
`endif

    mem_loader #(.DATA_W(8), .ADDR_W(10), .DEPTH(4), .BASE_ADDR(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .finish(finish_a),
        .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_rdata(rdata_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
`ifdef MEM_LOADER_CHECKSUM_EN
        , .checksum(checksum_a)
`endif
    );

    mem_loader #(.DATA_W(8), .ADDR_W(2), .DEPTH(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .finish(finish_b),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_rdata(rdata_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
`ifdef MEM_LOADER_CHECKSUM_EN
        , .checksum(checksum_b)
`endif
    );

    always @(posedge clk) begin
        if (mem_en_a) rdata_a <= mem_a[mem_addr_a];
        if (mem_en_b) rdata_b <= mem_b[mem_addr_b];
        if (wr_en_a)  wcnt_a  <= wcnt_a + 1;
        if (wr_en_b)  wcnt_b  <= wcnt_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs edges E0..E0+5 of a DEPTH=4 load on instance A; start must already be high.
    task automatic load_a(input bit drop_early);
        int snap;
        snap = wcnt_a;
        for (int k = 0; k <= 5; k++) begin
            step();
            if (drop_early && k == 1) start_a = 1'b0;
            chk($sformatf("a.mem_en k%0d", k), 32'(mem_en_a), 32'(k < 4));
            if (k < 4) chk($sformatf("a.mem_addr k%0d", k), 32'(mem_addr_a), 32'(8 + k));
            chk($sformatf("a.wr_en k%0d", k), 32'(wr_en_a), 32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) begin
                chk($sformatf("a.wr_addr k%0d", k), 32'(wr_addr_a), 32'(k - 1));
                chk($sformatf("a.wr_data k%0d", k), 32'(wr_data_a), 32'(k));
            end
            chk($sformatf("a.finish k%0d", k), 32'(finish_a), 32'(k >= 5));
`ifdef MEM_LOADER_CHECKSUM_EN
            if (k == 0) chk("a.sum cleared", 32'(checksum_a), 32'd0);
            if (k == 5) chk("a.sum final", 32'(checksum_a), 32'd10);
`endif
        end
        chk("a.write count", 32'(wcnt_a - snap), 32'd4);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_a[i] = 8'((i * 3 + 7) & 8'hFF);
        mem_a[8] = 8'd1; mem_a[9] = 8'd2; mem_a[10] = 8'd3; mem_a[11] = 8'd4;
        for (int i = 0; i < 4; i++) mem_b[i] = 8'hFF;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst.finish", 32'(finish_a), 32'd0);
        chk("rst.mem_en", 32'(mem_en_a), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr_a), 32'd8);
        chk("rst.wr_en", 32'(wr_en_a), 32'd0);
        chk("rst.wr_addr", 32'(wr_addr_a), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("idle.mem_en", 32'(mem_en_a), 32'd0);

        // Basic load plus handshake release
        start_a = 1'b1;
        load_a(1'b0);
        step();
        chk("hs.finish k6", 32'(finish_a), 32'd1);
        chk("hs.mem_en k6", 32'(mem_en_a), 32'd0);
        step();
        chk("hs.finish k7", 32'(finish_a), 32'd1);
        chk("hs.mem_en k7", 32'(mem_en_a), 32'd0);
`ifdef MEM_LOADER_CHECKSUM_EN
        chk("hs.sum stable", 32'(checksum_a), 32'd10);
`endif
        start_a = 1'b0;
        step();
        chk("hs.finish fall", 32'(finish_a), 32'd0);
        chk("hs.mem_en after", 32'(mem_en_a), 32'd0);

        // Early drop during FETCH
        start_a = 1'b1;
        load_a(1'b1);
        step();
        chk("drop.finish one cycle", 32'(finish_a), 32'd0);
        step();
        chk("drop.idle mem_en", 32'(mem_en_a), 32'd0);
        chk("drop.idle finish", 32'(finish_a), 32'd0);

        // Asynchronous reset after two writes
        start_a = 1'b1;
        step(); step(); step();
        chk("mid.wr_addr before rst", 32'(wr_addr_a), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid.mem_en", 32'(mem_en_a), 32'd0);
        chk("mid.mem_addr", 32'(mem_addr_a), 32'd8);
        chk("mid.wr_en", 32'(wr_en_a), 32'd0);
        chk("mid.wr_addr", 32'(wr_addr_a), 32'd0);
        chk("mid.finish", 32'(finish_a), 32'd0);
`ifdef MEM_LOADER_CHECKSUM_EN
        chk("mid.sum", 32'(checksum_a), 32'd0);
`endif
        #2 rst = 1'b1;
        load_a(1'b0);

        // Back-to-back: drop for one cycle then request again
        start_a = 1'b0;
        step();
        chk("b2b.finish fall", 32'(finish_a), 32'd0);
        start_a = 1'b1;
        load_a(1'b0);
        start_a = 1'b0;
        step();
        chk("b2b.end finish", 32'(finish_a), 32'd0);

        // Boundary: whole 2-bit address space, all 0xFF
        start_b = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            step();
            chk($sformatf("b.mem_en k%0d", k), 32'(mem_en_b), 32'(k < 4));
            if (k < 4) chk($sformatf("b.mem_addr k%0d", k), 32'(mem_addr_b), 32'(k));
            chk($sformatf("b.wr_en k%0d", k), 32'(wr_en_b), 32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) begin
                chk($sformatf("b.wr_addr k%0d", k), 32'(wr_addr_b), 32'(k - 1));
                chk($sformatf("b.wr_data k%0d", k), 32'(wr_data_b), 32'hFF);
            end
            chk($sformatf("b.finish k%0d", k), 32'(finish_b), 32'(k >= 5));
        end
        chk("b.write count", 32'(wcnt_b), 32'd4);
`ifdef MEM_LOADER_CHECKSUM_EN
        chk("b.sum", 32'(checksum_b), 32'h03FC);
`endif
        start_b = 1'b0;
        step();
        chk("b.finish fall", 32'(finish_b), 32'd0);
        chk("b.no extra read", 32'(mem_en_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Responder side of the controller's load handshake. On a level `start` request it streams `DEPTH` words from a synchronous-read source memory into the compute-side buffer, then raises `finish` and holds it until the request drops. Two instances sit behind the top-level controller:

- one answers `start_read_w` / `read_weights_finish` and loads the weight buffer;
- one answers `start_read_i` / `read_inputs_finish` and loads the input buffer.

## Interface
Parameters:
- `DATA_W`, default 8: word width.
- `ADDR_W`, default 10: address width on both the memory and the buffer side.
- `DEPTH`, default 784: words per load, 1..2^ADDR_W.
- `BASE_ADDR`, default 0: first source address. `BASE_ADDR+DEPTH` must be ≤ 2^ADDR_W.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: load request, level; held high by the controller until it sees `finish`.
- `finish` out 1: load complete, registered; held until `start` is low.
- `mem_en` out 1: source read enable.
- `mem_addr` out ADDR_W: source read address.
- `mem_rdata` in DATA_W: source data, valid the cycle after `mem_en`.
- `wr_en` out 1: buffer write strobe.
- `wr_addr` out ADDR_W: buffer index, 0..DEPTH-1.
- `wr_data` out DATA_W: buffer write data, equal to `mem_rdata`.
- `checksum` out 16: present only with `MEM_LOADER_CHECKSUM_EN`.

## Operation
- **Reset values:**
  - state IDLE;
  - `finish`, `mem_en`, `wr_en` = 0;
  - `mem_addr` = BASE_ADDR;
  - `wr_addr` = 0;
  - read count = 0;
  - `checksum` = 0.
- **IDLE:**
  - Outputs quiet.
  - `start`=1 at an edge → FETCH. At that edge the read count is cleared and, if enabled, `checksum` is cleared.
- **FETCH:**
  - `mem_en`=1 and `mem_addr`=BASE_ADDR+rd_cnt every cycle.
  - rd_cnt increments each cycle.
  - When rd_cnt==DEPTH-1 is issued → DRAIN.
- **DRAIN:** one cycle, `mem_en`=0, the last read returns → DONE.
- **DONE:**
  - `finish`=1.
  - While `start`=1, stay in DONE.
  - `start`=0 → IDLE with `finish`=0 at the same edge.
- **Write side:**
  - `wr_en` is `mem_en` delayed one cycle.
  - `wr_addr` is rd_cnt delayed one cycle.
  - `wr_data`=`mem_rdata` (combinational pass).
  - Exactly DEPTH writes per load, indices 0..DEPTH-1 in order, no gaps.
- **`start` dropping in FETCH/DRAIN:** ignored. The load completes, DONE is entered, `finish` is high for exactly one cycle, then the block returns to IDLE.
- **`start` high again in IDLE right after DONE:** a new full load begins. A new load is never started from DONE.
- **DEPTH=1:** FETCH lasts one cycle, then DRAIN.
- **Address arithmetic:** rd_cnt is ADDR_W+1 bits wide, so the terminal compare never wraps when DEPTH=2^ADDR_W. `mem_addr` is taken modulo 2^ADDR_W.
- **`rst` low at any time:** all state and outputs go to reset values immediately (asynchronous). A partial buffer load is not reported.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- `mem_en` is high for cycles E0..E0+DEPTH-1.
- The first `wr_en` is in the cycle after E0.
- The last `wr_en` is in the DRAIN cycle.
- `finish` rises at edge E0+DEPTH+1, i.e. DEPTH+1 cycles after the request is sampled.
- `finish` falls at the first edge that samples `start`=0.
- Minimum IDLE→IDLE round trip is DEPTH+2 cycles.
- Throughput is one word per cycle. There is no back-pressure, and the buffer must accept a write every cycle.

## Configuration
`MEM_LOADER_CHECKSUM_EN`:
- **Defined:**
  - `checksum` = 16-bit modulo-2^16 sum of all `wr_data` zero-extended, accumulated on each `wr_en` cycle.
  - Cleared on the IDLE→FETCH edge.
  - Stable and valid while `finish`=1.
- **Undefined:** no `checksum` port and no accumulator logic. All other behaviour is identical.

## Structure
- **Shared package `ctrl_pkg`:**
  - loader state encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3, 2 bits);
  - CHK_W=16;
  - default DATA_W/ADDR_W;
  - weight/input DEPTH and BASE_ADDR constants used by the controller-level instances.
- **Sub-module `mem_loader_chk`:**
  - 16-bit accumulator with clear/enable inputs;
  - instantiated only under `MEM_LOADER_CHECKSUM_EN`.
- FSM, counters and the write-delay registers stay in `mem_loader`.

## Test plan
- **Basic load:** DEPTH=4, BASE_ADDR=8, memory[8..11]={1,2,3,4}, `start` held high.
  - `mem_addr` reads 8,9,10,11.
  - Writes are (0,1),(1,2),(2,3),(3,4).
  - `finish` rises 5 cycles after the sampling edge; `checksum`=10.
- **Handshake release:** `start` held 3 cycles after `finish`.
  - `finish` stays high 3 cycles and falls at the edge sampling `start`=0.
  - No extra `mem_en`.
- **Early drop:** `start` falls during FETCH (DEPTH=4).
  - All 4 writes still occur; `finish` is high for exactly 1 cycle; back to IDLE.
- **Reset mid-load:** `rst` low asynchronously after 2 writes.
  - All outputs go to reset values at once.
  - A following `start` reloads from index 0.
- **Boundary:** ADDR_W=2, DEPTH=4, BASE_ADDR=0, memory = 0xFF×4.
  - Addresses 0..3, no wrap, no early termination.
  - `checksum`=0x03FC.
- **Back-to-back loads:** `start` re-asserted one cycle after it drops.
  - Second load is identical and `checksum` restarts from 0.
